// File: rtl/bht_2bit.sv
// bht_2bit: branch history table of 2-bit saturating counters indexed by PC word address,
// with a saturating misprediction counter for performance debug.
module bht_2bit #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [31:0]      if_pc,
  output logic [1:0]       if_ctr,
  output logic             if_pred_taken,
  input  logic             upd_en,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic             upd_pred,
  output logic [CNT_W-1:0] mispredict_cnt
);
  logic [1:0] tbl [2**IDX_W];
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [1:0] cur, nxt;
  assign rd_idx = if_pc[IDX_W+1:2];
  assign wr_idx = upd_pc[IDX_W+1:2];
  assign if_ctr = tbl[rd_idx];
  assign if_pred_taken = if_ctr[1];
  assign cur = tbl[wr_idx];
  // Saturating step from the table's current value; no bypass to the read port.
  assign nxt = upd_taken ? ((cur == 2'b11) ? cur : cur + 2'd1)
                         : ((cur == 2'b00) ? cur : cur - 2'd1);
  always_ff @(posedge clk) begin
    if (!clrn) begin
      for (int i = 0; i < 2**IDX_W; i++) tbl[i] <= 2'b01;
      mispredict_cnt <= '0;
    end else if (upd_en) begin
      tbl[wr_idx] <= nxt;
      if (upd_pred != upd_taken && mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end
endmodule

// File: doc/bht_2bit.md
Name: bht_2bit

Overview:
- Branch history table of 2-bit saturating counters, indexed by PC word address.
- Sits in IF, directly upstream of the 2-bit pipeline register (`dff2`), which carries the counter read for the fetched branch down to ID/EX.
- EX resolves the branch and writes the outcome back to the table.
- Also keeps a saturating misprediction counter for performance debug.

Parameters:
- IDX_W, 6, index width; table depth is 2^IDX_W entries, indexed by pc[IDX_W+1:2].
- CNT_W, 16, width of the misprediction counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- clrn  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- if_pc  in  32  PC of the instruction being fetched.
- if_ctr  out  2  counter value at index(if_pc); feeds the dff2 stage register.
- if_pred_taken  out  1  equals if_ctr[1].
- upd_en  in  1  EX has resolved a conditional branch this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual outcome: 1 = taken.
- upd_pred  in  1  prediction that was made for this branch (carried down the pipeline).
- mispredict_cnt  out  CNT_W  number of resolved branches with upd_pred != upd_taken.

Behaviour:
- Storage: 2^IDX_W entries, 2 bits each, held in flops, no RAM.
- Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset:
  - When clrn==0 at a rising edge, every entry becomes 01 and mispredict_cnt becomes 0.
  - Reset is synchronous; clrn is ignored between edges.
  - Reset overrides any simultaneous update.
  - Reset in the middle of a branch sequence discards all history.
- Read path:
  - Purely combinational from the table: if_ctr = table[if_pc[IDX_W+1:2]].
  - Zero-cycle read latency.
  - if_pc[1:0] and the bits above the index are ignored, so aliasing is allowed.
- Update (rising edge, clrn==1, upd_en==1), with idx = upd_pc[IDX_W+1:2] and c = table[idx]:
  - If upd_taken: new = (c==11) ? 11 : c+1.
  - Else: new = (c==00) ? 00 : c-1.
  - Counters saturate, never wrap.
  - The update uses the table's current value at idx, not a value carried down the pipeline.
- Timing: the update is visible on if_ctr from the cycle after the edge.
- Same-cycle read/write of the same index: if_ctr returns the pre-update value. There is no bypass.
- upd_en==0: table unchanged. upd_pc, upd_taken and upd_pred are don't-care.
- Misprediction counter:
  - Increments by 1 on an edge where clrn==1, upd_en==1 and upd_pred != upd_taken.
  - Saturates at 2^CNT_W-1 and does not wrap.
- No state machine beyond the per-entry counters. Exactly one update per cycle.
- Stall handling is the consumer's job: the dff2 stage register holds its value, and if_pc is held by the PC register.
- No X propagation: all outputs are defined from the first edge with clrn==0.

Test Plan:
- Reset and initial read:
  - Stimulus: hold clrn=0 for 2 edges, then release; sweep if_pc = 0x00, 0x04, …, 0xFC.
  - Required: every if_ctr = 01, if_pred_taken = 0, mispredict_cnt = 0.
- Saturation upward:
  - Stimulus: 4 taken updates at upd_pc=0x40 with upd_pred=0.
  - Required: if_pc=0x40 reads 10, 11, 11, 11 after the successive edges; mispredict_cnt = 4.
- Saturation downward and hysteresis:
  - Stimulus: from 11, apply not-taken updates.
  - Required: reads go 10 (pred still 1), 01 (pred 0), 00, 00.
- Same-index read during write, and aliasing:
  - Stimulus: with if_pc = upd_pc = 0x80 in the same cycle, drive a taken update.
  - Required: if_ctr shows the old 01 that cycle and 10 the next cycle.
  - Then read if_pc = 0x180 (same index, IDX_W=6). Required: also reads 10.
- Reset mid-operation:
  - Stimulus: train entry 0x40 to 11 with mispredict_cnt = 3; assert clrn=0 in the same cycle as upd_en=1.
  - Required: after the edge, entry 0x40 = 01 and mispredict_cnt = 0. The update is lost.
- Counter saturation:
  - Stimulus: CNT_W=4; drive 20 mispredicting updates.
  - Required: mispredict_cnt stops at 15.
  - Then drive upd_en=0 with upd_pred != upd_taken. Required: no change.
